// File: rtl/led_matrix6x6_scan.sv
// Row-multiplexed scan driver for a 6x6 LED matrix.
// Latches the six row bytes once per frame, then lights one row at a time with a
// programmable dwell and an optional dark gap, so a frame never tears on the panel.
module led_matrix6x6_scan #(
  parameter int unsigned DWELL   = 4,
  parameter int unsigned BLANK   = 1,
  parameter bit          COL_INV = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] row0,
  input  logic [5:0] row1,
  input  logic [5:0] row2,
  input  logic [5:0] row3,
  input  logic [5:0] row4,
  input  logic [5:0] row5,
  output logic [5:0] row_sel,
  output logic [5:0] col,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int unsigned DW_W    = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
  localparam int unsigned BL_W    = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
  localparam int unsigned DW_LAST = (DWELL > 0) ? DWELL - 1 : 0;
  localparam int unsigned BL_LAST = (BLANK > 0) ? BLANK - 1 : 0;
  localparam int unsigned ROWS    = 6;
  localparam logic [5:0]  DARK_COL = {6{COL_INV}};

  // A zero dwell would never light a row.
  generate
    if (DWELL < 1) begin : g_bad_dwell
      $error("led_matrix6x6_scan: DWELL must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ON    = 2'd2,
    S_BLANK = 2'd3
  } state_t;

  state_t                r_state;
  logic [2:0]            r_idx;
  logic [DW_W-1:0]       r_dwell;
  logic [BL_W-1:0]       r_blank;
  logic [ROWS-1:0][5:0]  r_shadow;

  state_t                w_state_nxt;
  logic [2:0]            w_idx_nxt;
  logic [DW_W-1:0]       w_dwell_nxt;
  logic [BL_W-1:0]       w_blank_nxt;
  logic                  w_row_end;
  logic                  w_eof;
  logic [5:0]            w_shadow_sel;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, row index and dwell/blank counter sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_dwell_nxt = r_dwell;
    w_blank_nxt = r_blank;
    w_row_end   = 1'b0;
    w_eof       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_state_nxt = S_ON;
        w_idx_nxt   = 3'd0;
        w_dwell_nxt = '0;
      end
      S_ON: begin
        if (r_dwell == DW_W'(DW_LAST)) begin
          w_dwell_nxt = '0;
          if (BLANK > 0) begin
            w_state_nxt = S_BLANK;
            w_blank_nxt = '0;
          end else begin
            w_row_end = 1'b1;
          end
        end else begin
          w_dwell_nxt = r_dwell + DW_W'(1);
        end
      end
      S_BLANK: begin
        if (r_blank == BL_W'(BL_LAST)) begin
          w_blank_nxt = '0;
          w_row_end   = 1'b1;
        end else begin
          w_blank_nxt = r_blank + BL_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A finished row either advances to the next row or closes the frame.
    if (w_row_end) begin
      if (r_idx == 3'd5) begin
        w_eof       = 1'b1;
        w_state_nxt = en ? S_LOAD : S_IDLE;
      end else begin
        w_state_nxt = S_ON;
        w_idx_nxt   = r_idx + 3'd1;
      end
    end
  end

  assign w_shadow_sel = r_shadow[w_idx_nxt];

  // Index and counters follow the comb sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= 3'd0;
      r_dwell <= '0;
      r_blank <= '0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_dwell <= w_dwell_nxt;
      r_blank <= w_blank_nxt;
    end
  end

  // Snapshot the frame on the edge that enters LOAD; held until the next LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (w_state_nxt == S_LOAD) begin
      r_shadow <= {row5, row4, row3, row2, row1, row0};
    end
  end

  // Registered outputs decoded from the upcoming state, so select and data move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_sel     <= 6'd0;
      col         <= DARK_COL;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      frame_start <= (w_state_nxt == S_LOAD);
      if (w_state_nxt == S_ON) begin
        row_sel <= 6'(6'd1 << w_idx_nxt);
        col     <= w_shadow_sel ^ DARK_COL;
      end else begin
        row_sel <= 6'd0;
        col     <= DARK_COL;
      end
      if (w_eof) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_led_matrix6x6_scan.sv
// Bench for led_matrix6x6_scan: two instances (gapped, and inverted gapless) checked
// every cycle against a frame-position model, plus directed vectors and sequences.
module tb_led_matrix6x6_scan;

  logic       clk;
  logic       rst;
  logic       en;
  logic [5:0] ra [6];
  logic [5:0] rb [6];
  logic [5:0] rs_o  [2];
  logic [5:0] col_o [2];
  logic       fs_o  [2];
  logic [7:0] fc_o  [2];

  int checks   = 0;
  int failures = 0;

  led_matrix6x6_scan #(.DWELL(4), .BLANK(1), .COL_INV(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en),
    .row0(ra[0]), .row1(ra[1]), .row2(ra[2]), .row3(ra[3]), .row4(ra[4]), .row5(ra[5]),
    .row_sel(rs_o[0]), .col(col_o[0]), .frame_start(fs_o[0]), .frame_cnt(fc_o[0])
  );

  led_matrix6x6_scan #(.DWELL(4), .BLANK(0), .COL_INV(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en(en),
    .row0(rb[0]), .row1(rb[1]), .row2(rb[2]), .row3(rb[3]), .row4(rb[4]), .row5(rb[5]),
    .row_sel(rs_o[1]), .col(col_o[1]), .frame_start(fs_o[1]), .frame_cnt(fc_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int unsigned m_dw(input int i);
    return (i == 0) ? 4 : 4;
  endfunction
  function automatic int unsigned m_bl(input int i);
    return (i == 0) ? 1 : 0;
  endfunction
  function automatic logic [5:0] m_dark(input int i);
    return (i == 0) ? 6'h00 : 6'h3F;
  endfunction
  function automatic int unsigned m_period(input int i);
    return 1 + 6 * (m_dw(i) + m_bl(i));
  endfunction

  bit          m_act  [2];
  int unsigned m_t    [2];
  logic [7:0]  m_cnt  [2];
  logic [5:0]  m_snap [2][6];

  // Model tracks "active frame, cycle position t" rather than any FSM state.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0;
        m_t[i]   <= 0;
        m_cnt[i] <= 8'd0;
        for (int r = 0; r < 6; r++) m_snap[i][r] <= 6'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_act[i]) begin
          if (en) begin
            m_act[i] <= 1'b1;
            m_t[i]   <= 0;
            for (int r = 0; r < 6; r++) m_snap[i][r] <= (i == 0) ? ra[r] : rb[r];
          end
        end else if (m_t[i] == m_period(i) - 1) begin
          m_cnt[i] <= m_cnt[i] + 8'd1;
          if (en) begin
            m_t[i] <= 0;
            for (int r = 0; r < 6; r++) m_snap[i][r] <= (i == 0) ? ra[r] : rb[r];
          end else begin
            m_act[i] <= 1'b0;
          end
        end else begin
          m_t[i] <= m_t[i] + 1;
        end
      end
    end
  end

  function automatic void m_expect(input int i, output logic [5:0] rs,
                                   output logic [5:0] cl, output logic fs);
    int unsigned k, r, w;
    rs = 6'd0;
    cl = m_dark(i);
    fs = 1'b0;
    if (m_act[i]) begin
      if (m_t[i] == 0) begin
        fs = 1'b1;
      end else begin
        k = m_t[i] - 1;
        r = k / (m_dw(i) + m_bl(i));
        w = k % (m_dw(i) + m_bl(i));
        if (w < m_dw(i)) begin
          rs = 6'(6'd1 << r);
          cl = m_snap[i][r] ^ m_dark(i);
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Every cycle both instances are compared with the model.
  always @(negedge clk) begin
    logic [5:0] ers, ecl;
    logic       efs;
    for (int i = 0; i < 2; i++) begin
      m_expect(i, ers, ecl, efs);
      chk($sformatf("model%0d.row_sel", i), {2'b0, rs_o[i]},  {2'b0, ers});
      chk($sformatf("model%0d.col", i),     {2'b0, col_o[i]}, {2'b0, ecl});
      chk($sformatf("model%0d.frame_start", i), {7'b0, fs_o[i]}, {7'b0, efs});
      chk($sformatf("model%0d.frame_cnt", i), fc_o[i], m_cnt[i]);
    end
  end

  // Bounded wait on dut_a: kind 0 = row_sel equals v, kind 1 = frame_start pulse.
  task automatic wait_a(input int kind, input logic [5:0] v, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!((kind == 0) ? (rs_o[0] == v) : (fs_o[0] == 1'b1)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL timeout %s got=none exp=event", nm);
    end
  endtask

  typedef struct {
    int unsigned off;
    int          which;
    logic [5:0]  rs;
    logic [5:0]  cl;
    logic        fs;
    logic [7:0]  fc;
  } vec_t;

  vec_t tbl [19];

  initial begin
    logic [7:0] fc0;
    logic [7:0] fc_prev;
    int         n_fs;
    bit         seen4, seen5, saw_wrap;

    // Offsets count from the first frame_start cycle after en rises from IDLE.
    tbl[0]  = '{0,  0, 6'h00, 6'h00, 1'b1, 8'd0};
    tbl[1]  = '{1,  0, 6'h01, 6'h01, 1'b0, 8'd0};
    tbl[2]  = '{4,  0, 6'h01, 6'h01, 1'b0, 8'd0};
    tbl[3]  = '{5,  0, 6'h00, 6'h00, 1'b0, 8'd0};
    tbl[4]  = '{6,  0, 6'h02, 6'h02, 1'b0, 8'd0};
    tbl[5]  = '{26, 0, 6'h20, 6'h20, 1'b0, 8'd0};
    tbl[6]  = '{29, 0, 6'h20, 6'h20, 1'b0, 8'd0};
    tbl[7]  = '{30, 0, 6'h00, 6'h00, 1'b0, 8'd0};
    tbl[8]  = '{31, 0, 6'h00, 6'h00, 1'b1, 8'd1};
    tbl[9]  = '{0,  1, 6'h00, 6'h3F, 1'b1, 8'd0};
    tbl[10] = '{1,  1, 6'h01, 6'h1E, 1'b0, 8'd0};
    tbl[11] = '{4,  1, 6'h01, 6'h1E, 1'b0, 8'd0};
    tbl[12] = '{5,  1, 6'h02, 6'h2D, 1'b0, 8'd0};
    tbl[13] = '{9,  1, 6'h04, 6'h33, 1'b0, 8'd0};
    tbl[14] = '{13, 1, 6'h08, 6'h33, 1'b0, 8'd0};
    tbl[15] = '{17, 1, 6'h10, 6'h2D, 1'b0, 8'd0};
    tbl[16] = '{21, 1, 6'h20, 6'h1E, 1'b0, 8'd0};
    tbl[17] = '{24, 1, 6'h20, 6'h1E, 1'b0, 8'd0};
    tbl[18] = '{25, 1, 6'h00, 6'h3F, 1'b1, 8'd1};

    rst = 1'b1;
    en  = 1'b0;
    for (int r = 0; r < 6; r++) begin
      ra[r] = 6'd0;
      rb[r] = 6'd0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle with scan disabled: everything stays dark and counters hold.
    repeat (50) @(negedge clk);
    chk("idle.row_sel", {2'b0, rs_o[0]}, 8'h00);
    chk("idle.col", {2'b0, col_o[0]}, 8'h00);
    chk("idle.frame_cnt", fc_o[0], 8'h00);
    chk("idle.inv_col", {2'b0, col_o[1]}, 8'h3F);

    // First frame of both instances against the vector table.
    ra = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};
    rb = '{6'h21, 6'h12, 6'h0C, 6'h0C, 6'h12, 6'h21};
    en = 1'b1;
    for (int c = 0; c <= 31; c++) begin
      @(negedge clk);
      for (int k = 0; k < 19; k++) begin
        if (tbl[k].off == c) begin
          chk($sformatf("tbl%0d.row_sel", k), {2'b0, rs_o[tbl[k].which]}, {2'b0, tbl[k].rs});
          chk($sformatf("tbl%0d.col", k), {2'b0, col_o[tbl[k].which]}, {2'b0, tbl[k].cl});
          chk($sformatf("tbl%0d.frame_start", k), {7'b0, fs_o[tbl[k].which]}, {7'b0, tbl[k].fs});
          chk($sformatf("tbl%0d.frame_cnt", k), fc_o[tbl[k].which], tbl[k].fc);
        end
      end
    end

    // Mid-frame input change is held off until the next snapshot.
    ra[2] = 6'h00;
    wait_a(1, 6'h00, "tear.fs1");
    wait_a(0, 6'h02, "tear.row1");
    ra[2] = 6'h3F;
    wait_a(0, 6'h04, "tear.row2a");
    chk("tear.old_frame_col", {2'b0, col_o[0]}, 8'h00);
    wait_a(1, 6'h00, "tear.fs2");
    wait_a(0, 6'h04, "tear.row2b");
    chk("tear.new_frame_col", {2'b0, col_o[0]}, 8'h3F);

    // Dropping en during row 3 finishes the frame, then stays idle.
    wait_a(0, 6'h08, "stop.row3");
    en    = 1'b0;
    fc0   = fc_o[0];
    n_fs  = 0;
    seen4 = 1'b0;
    seen5 = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (fs_o[0]) n_fs++;
      if (rs_o[0] == 6'h10) seen4 = 1'b1;
      if (rs_o[0] == 6'h20) seen5 = 1'b1;
    end
    chk("stop.rows4_5_shown", {6'b0, seen4, seen5}, 8'h03);
    chk("stop.no_frame_start", 8'(n_fs), 8'd0);
    chk("stop.frame_cnt", fc_o[0], fc0 + 8'd1);
    chk("stop.dark", {2'b0, rs_o[0]}, 8'h00);

    // Async reset in the middle of row 4 darkens outputs before the next edge.
    en = 1'b1;
    wait_a(1, 6'h00, "rst.fs");
    wait_a(0, 6'h10, "rst.row4");
    #2 rst = 1'b1;
    #1;
    chk("rst.row_sel", {2'b0, rs_o[0]}, 8'h00);
    chk("rst.col", {2'b0, col_o[0]}, 8'h00);
    chk("rst.frame_cnt", fc_o[0], 8'h00);
    chk("rst.inv_col", {2'b0, col_o[1]}, 8'h3F);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.load_pulse", {7'b0, fs_o[0]}, 8'h01);
    @(negedge clk);
    chk("rst.first_row", {2'b0, rs_o[0]}, 8'h01);
    chk("rst.first_col", {2'b0, col_o[0]}, 8'h01);

    // Long enabled run with random rows: frame_cnt must wrap 255 -> 0.
    saw_wrap = 1'b0;
    fc_prev  = fc_o[0];
    repeat (8100) begin
      @(negedge clk);
      for (int r = 0; r < 6; r++) begin
        ra[r] = 6'($urandom_range(0, 63));
        rb[r] = 6'($urandom_range(0, 63));
      end
      if (fc_prev == 8'd255 && fc_o[0] == 8'd0) saw_wrap = 1'b1;
      fc_prev = fc_o[0];
    end
    chk("wrap.seen", {7'b0, saw_wrap}, 8'h01);

    // Random en, rows and occasional reset pulses.
    repeat (1500) begin
      @(negedge clk);
      en = ($urandom_range(0, 7) != 0);
      for (int r = 0; r < 6; r++) begin
        ra[r] = 6'($urandom_range(0, 63));
        rb[r] = 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
